replay_sequencer: RTL
=====================

Name: replay_sequencer

Overview:
- Parametrised successor of the network's reward-gated replay path: records per-timestep spike vectors of all three layers into a ring buffer during the exploration phase.
- When an episode ends (break_in rises) and reward_in is set, it replays the stored sequence as injected current for the neuron array, repeated REPLAY_REPS times, with learning-rest pulses.
- Sits between the neuron array (spike source and current sink) and the control unit that raises break_in.
- Generalises layer widths, history depth, repetitions and frame timing.

Parameters:
- N_L1, 6, input-layer neurons
- N_L2, 8, hippocampal-layer neurons
- N_L3, 2, output-layer neurons (NT = N_L1+N_L2+N_L3)
- BUF, 16, current word width (buffer_size)
- HIST_DEPTH, 10, frames stored (>=2)
- REPLAY_REPS, 3, replay repetitions per rewarded episode (>=1)
- FRAME_CYC, 2, cycles each replayed frame is driven (>=1)
- GAP_CYC, 4, zero-current cycles after each frame (>=0)
- I_REPLAY, 16'h0800, current injected per active bit

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- active  in  1  sample strobe; frame recorded when high in RECORD
- spikes_in  in  NT  current spike vector, bit i = neuron i
- break_in  in  1  episode-end level from control unit
- reward_in  in  1  sampled on break_in rising edge
- replay_iin  out  NT*BUF  registered current vector, word i at [(i+1)*BUF-1 -: BUF]
- learning_rest  out  1  one-cycle pulse at start of each repetition
- start_replay  out  1  one-cycle pulse on entering replay
- replay_busy  out  1  high in ARM/FRAME/GAP
- finish_replay  out  1  one-cycle pulse on entering DONE
- hist_count  out  $clog2(HIST_DEPTH+1)  valid frames stored

Behaviour:
- Reset: state RECORD; wr_ptr=0; hist_count=0; break_dly=0; all outputs 0. Reset mid-replay aborts immediately.
- brk_edge = break_in & ~break_dly, with break_dly a register.
- RECORD: on active & ~brk_edge, write spikes_in at wr_ptr. wr_ptr wraps HIST_DEPTH-1 -> 0. hist_count saturates at HIST_DEPTH; when full, the oldest frame is overwritten. The frame on the brk_edge cycle is not recorded.
- RECORD -> ARM on brk_edge & reward_in & hist_count>0. Otherwise brk_edge -> DONE (no replay).
- ARM (1 cycle): start_replay=1, learning_rest=1; rep=0. Read pointer = oldest frame = (wr_ptr - hist_count) mod HIST_DEPTH.
- FRAME: hold for FRAME_CYC cycles. replay_iin word i = I_REPLAY if frame bit i set, else 0. First frame appears the cycle after ARM.
- FRAME -> GAP, or directly to the next FRAME if GAP_CYC=0. In GAP, replay_iin=0.
- After the last frame (newest) of a repetition: rep+1. If rep<REPLAY_REPS, restart from the oldest frame with a 1-cycle learning_rest pulse on the first FRAME cycle. Otherwise -> DONE.
- DONE: finish_replay pulses on entry; replay_iin=0. Waits for break_in=0 -> RECORD, clearing hist_count and wr_ptr.
- break_in falling during ARM/FRAME/GAP: abort to RECORD next cycle, replay_iin=0, no finish pulse, history cleared.
- A further brk_edge during replay cannot occur, since break_in is held high. reward_in is ignored outside brk_edge.
- Cycles per repetition = hist_count*(FRAME_CYC+GAP_CYC).

Optional Feature:
- Macro REPLAY_REVERSE_EN.
- Defined: odd-indexed repetitions (rep=1,3,...) play newest -> oldest; even ones play forward.
- Undefined: all repetitions play forward; no reverse-pointer logic is built.

Decomposition:
- Package replay_pkg: state enum (RECORD, ARM, FRAME, GAP, DONE), NT localparam function, count-width function, default I_REPLAY.
- Sub-module hist_ring_buffer: NT-wide, HIST_DEPTH-deep register ring. Write port, async read by index, wr_ptr and saturating count.

Test Plan:
- HIST_DEPTH=4: record frames 0x0001..0x0006 (one per active cycle) -> hist_count=4; replay order 0x0003, 0x0004, 0x0005, 0x0006.
- Default params, 3 frames, break_in rises with reward_in=1 -> start_replay the next cycle. First frame on replay_iin 2 cycles after the edge. finish_replay at edge+2+3*3*6 cycles. learning_rest pulses 3 times.
- break_in rises with reward_in=0 -> finish_replay the next cycle, replay_iin stays 0, start_replay never pulses.
- break_in falls mid-GAP of repetition 2 -> RECORD next cycle, hist_count=0, no finish_replay.
- reset asserted during FRAME -> next cycle all outputs 0, hist_count=0. With REPLAY_REVERSE_EN and frames A,B,C -> A,B,C, C,B,A, A,B,C.

Source files
------------

// File: rtl/replay_pkg.sv
// -----------------------------------------------------------------------------
// replay_pkg
//
// Shared definitions for the reward-gated replay sequencer:
//   - state_t            : sequencer state encoding (RECORD, ARM, FRAME, GAP, DONE)
//   - nt_of()            : total neuron count across the three layers
//   - count_width()      : bits needed to hold values 0..n inclusive
//   - ptr_width()        : bits needed to index 0..n-1
//   - I_REPLAY_DEFAULT   : default injected current per active spike bit
//
// Optional feature macro used by the sequencer: REPLAY_REVERSE_EN.
// -----------------------------------------------------------------------------
package replay_pkg;

    typedef enum logic [2:0] {
        RECORD,
        ARM,
        FRAME,
        GAP,
        DONE
    } state_t;

    localparam logic [15:0] I_REPLAY_DEFAULT = 16'h0800;

    function automatic int nt_of(input int n_l1, input int n_l2, input int n_l3);
        return n_l1 + n_l2 + n_l3;
    endfunction

    function automatic int count_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    function automatic int ptr_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hist_ring_buffer.sv
// -----------------------------------------------------------------------------
// hist_ring_buffer
//
// WIDTH-bit, DEPTH-deep register ring holding the most recent frames.
// Writing past DEPTH frames overwrites the oldest entry; count saturates.
//
// Ports:
//   clk      in   system clock
//   reset    in   synchronous active-high reset of pointer and count
//   clear    in   synchronous clear of pointer and count (history discard)
//   wr_en    in   write wr_data at wr_ptr on this edge
//   wr_data  in   WIDTH-bit frame to store
//   rd_idx   in   read index (combinational read)
//   rd_data  out  frame stored at rd_idx
//   wr_ptr   out  next slot to be written
//   count    out  number of valid frames, 0..DEPTH
// -----------------------------------------------------------------------------
module hist_ring_buffer
    import replay_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 10,
    localparam int PW   = ptr_width(DEPTH),
    localparam int CW   = count_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [PW-1:0]    rd_idx,
    output logic [WIDTH-1:0] rd_data,
    output logic [PW-1:0]    wr_ptr,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the frame storage has no reset; validity is tracked by count,
    // so stale contents are never observed and the array maps to plain flops/RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (wr_en) begin
            wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (count != CW'(DEPTH)) begin
                count <= count + 1'b1;
            end
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/replay_sequencer.sv
// -----------------------------------------------------------------------------
// replay_sequencer
//
// Records per-timestep spike vectors of all three layers while exploring, and
// after a rewarded episode end replays the stored sequence (oldest -> newest)
// as injected current, REPLAY_REPS times, each frame held FRAME_CYC cycles and
// followed by GAP_CYC zero-current cycles. learning_rest pulses at the start of
// every repetition.
//
// Optional feature: define REPLAY_REVERSE_EN to play odd-numbered repetitions
// (rep = 1, 3, ...) newest -> oldest. Without it every repetition plays forward.
//
// Ports:
//   clk            in   system clock
//   reset          in   synchronous active-high reset (aborts any replay)
//   active         in   sample strobe; frame recorded when high in RECORD
//   spikes_in      in   NT-bit spike vector, bit i = neuron i
//   break_in       in   episode-end level from the control unit
//   reward_in      in   sampled on the break_in rising edge only
//   replay_iin     out  registered current vector, word i at [(i+1)*BUF-1 -: BUF]
//   learning_rest  out  one-cycle pulse at the start of each repetition
//   start_replay   out  one-cycle pulse on entering replay (ARM)
//   replay_busy    out  high in ARM/FRAME/GAP
//   finish_replay  out  one-cycle pulse on entering DONE
//   hist_count     out  number of valid frames stored
// -----------------------------------------------------------------------------
module replay_sequencer
    import replay_pkg::*;
#(
    parameter int N_L1        = 6,
    parameter int N_L2        = 8,
    parameter int N_L3        = 2,
    parameter int BUF         = 16,
    parameter int HIST_DEPTH  = 10,
    parameter int REPLAY_REPS = 3,
    parameter int FRAME_CYC   = 2,
    parameter int GAP_CYC     = 4,
    parameter logic [BUF-1:0] I_REPLAY = BUF'(I_REPLAY_DEFAULT),
    localparam int NT = nt_of(N_L1, N_L2, N_L3),
    localparam int CW = count_width(HIST_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              active,
    input  logic [NT-1:0]     spikes_in,
    input  logic              break_in,
    input  logic              reward_in,
    output logic [NT*BUF-1:0] replay_iin,
    output logic              learning_rest,
    output logic              start_replay,
    output logic              replay_busy,
    output logic              finish_replay,
    output logic [CW-1:0]     hist_count
);

    localparam int PW  = ptr_width(HIST_DEPTH);
    localparam int RW  = count_width(REPLAY_REPS);
    localparam int CYW = count_width((FRAME_CYC > GAP_CYC) ? FRAME_CYC : GAP_CYC);
    localparam logic [PW:0] DEPTH_EXT = (PW + 1)'(HIST_DEPTH);

    state_t state, next_state;

    logic           break_dly;
    logic           brk_edge;
    logic [PW-1:0]  fidx, fidx_next;   // frame position within the repetition
    logic [RW-1:0]  rep, rep_next;
    logic [CYW-1:0] cyc, cyc_next;     // cycles spent in current FRAME/GAP
    logic           advance;
    logic           rest_next, start_next, finish_next;
    logic           hist_clear;
    logic           wr_en;

    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_idx;
    logic [NT-1:0]  rd_data;
    logic [NT*BUF-1:0] iin_next;

    logic [PW:0]    wr_ext, cnt_ext, oldest, offs, sum;
    logic           reverse;

    assign brk_edge = break_in & ~break_dly;
    // A frame coinciding with the episode end belongs to no explored timestep.
    assign wr_en    = (state == RECORD) && active && !brk_edge;

    hist_ring_buffer #(
        .WIDTH (NT),
        .DEPTH (HIST_DEPTH)
    ) u_hist (
        .clk     (clk),
        .reset   (reset),
        .clear   (hist_clear),
        .wr_en   (wr_en),
        .wr_data (spikes_in),
        .rd_idx  (rd_idx),
        .rd_data (rd_data),
        .wr_ptr  (wr_ptr),
        .count   (hist_count)
    );

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        next_state  = state;
        fidx_next   = fidx;
        rep_next    = rep;
        cyc_next    = cyc;
        rest_next   = 1'b0;
        start_next  = 1'b0;
        finish_next = 1'b0;
        hist_clear  = 1'b0;
        advance     = 1'b0;

        unique case (state)
            RECORD: begin
                if (brk_edge) begin
                    if (reward_in && hist_count != '0) begin
                        next_state = ARM;
                        start_next = 1'b1;
                        rest_next  = 1'b1;
                        fidx_next  = '0;
                        rep_next   = '0;
                        cyc_next   = '0;
                    end else begin
                        next_state  = DONE;
                        finish_next = 1'b1;
                    end
                end
            end
            ARM: begin
                if (!break_in) begin
                    next_state = RECORD;
                    hist_clear = 1'b1;
                end else begin
                    next_state = FRAME;
                end
            end
            FRAME: begin
                if (!break_in) begin
                    next_state = RECORD;
                    hist_clear = 1'b1;
                end else if (cyc == CYW'(FRAME_CYC - 1)) begin
                    cyc_next = '0;
                    if (GAP_CYC > 0) begin
                        next_state = GAP;
                    end else begin
                        advance = 1'b1;
                    end
                end else begin
                    cyc_next = cyc + 1'b1;
                end
            end
            GAP: begin
                if (!break_in) begin
                    next_state = RECORD;
                    hist_clear = 1'b1;
                end else if (cyc == CYW'(GAP_CYC - 1)) begin
                    cyc_next = '0;
                    advance  = 1'b1;
                end else begin
                    cyc_next = cyc + 1'b1;
                end
            end
            DONE: begin
                if (!break_in) begin
                    next_state = RECORD;
                    hist_clear = 1'b1;
                end
            end
            default: next_state = RECORD;
        endcase

        // Step to the next frame; wrapping past the newest frame ends a repetition.
        if (advance) begin
            next_state = FRAME;
            if (CW'(fidx) == hist_count - 1'b1) begin
                fidx_next = '0;
                if (rep == RW'(REPLAY_REPS - 1)) begin
                    next_state  = DONE;
                    finish_next = 1'b1;
                end else begin
                    rep_next  = rep + 1'b1;
                    rest_next = 1'b1;
                end
            end else begin
                fidx_next = fidx + 1'b1;
            end
        end
    end

    // Read address for the frame about to be driven. No writes happen during
    // replay, so wr_ptr and hist_count are stable and locate the oldest frame.
`ifdef REPLAY_REVERSE_EN
    assign reverse = rep_next[0];
`else
    assign reverse = 1'b0;
`endif

    always_comb begin
        wr_ext  = {1'b0, wr_ptr};
        cnt_ext = (PW + 1)'(hist_count);
        oldest  = (wr_ext >= cnt_ext) ? (wr_ext - cnt_ext) : (wr_ext + DEPTH_EXT - cnt_ext);
        offs    = reverse ? (cnt_ext - 1'b1 - {1'b0, fidx_next}) : {1'b0, fidx_next};
        sum     = oldest + offs;
        rd_idx  = (sum >= DEPTH_EXT) ? PW'(sum - DEPTH_EXT) : PW'(sum);
    end

    always_comb begin
        iin_next = '0;
        for (int i = 0; i < NT; i++) begin
            iin_next[i*BUF +: BUF] = ((next_state == FRAME) && rd_data[i]) ? I_REPLAY : '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= RECORD;
            break_dly     <= 1'b0;
            fidx          <= '0;
            rep           <= '0;
            cyc           <= '0;
            replay_iin    <= '0;
            learning_rest <= 1'b0;
            start_replay  <= 1'b0;
            replay_busy   <= 1'b0;
            finish_replay <= 1'b0;
        end else begin
            state         <= next_state;
            break_dly     <= break_in;
            fidx          <= fidx_next;
            rep           <= rep_next;
            cyc           <= cyc_next;
            replay_iin    <= iin_next;
            learning_rest <= rest_next;
            start_replay  <= start_next;
            replay_busy   <= next_state inside {ARM, FRAME, GAP};
            finish_replay <= finish_next;
        end
    end

endmodule
